// File: rtl/pump_pkg.sv
// Shared types, key codes and playfield geometry for the pump weapon.
package pump_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      RIGHT = 2'd2,
      LEFT  = 2'd3
   } pump_dir_t;

   typedef enum logic [1:0] {
      IDLE,
      EXTEND,
      ATTACHED,
      RETRACT
   } pump_state_t;

   localparam logic [7:0] KEY_SPACE = 8'd44;
   localparam logic [7:0] KEY_W     = 8'd26;
   localparam logic [7:0] KEY_S     = 8'd22;
   localparam logic [7:0] KEY_D     = 8'd7;
   localparam logic [7:0] KEY_A     = 8'd4;

   localparam int PLAY_W     = 512;
   localparam int PLAY_H     = 480;
   localparam int PUMP_REACH = 24;

   typedef struct packed {
      logic      ok;
      pump_dir_t dir;
   } fire_t;

   // Decide whether the pump fits on screen in the facing direction.
   function automatic fire_t fire_check(input logic [7:0] key,
                                        input logic [9:0] x,
                                        input logic [9:0] y);
      fire_t f;
      // NOTE: every field gets a value before the case so no path leaves it unassigned.
      f.ok  = 1'b0;
      f.dir = UP;
      case (key)
         KEY_W: begin
            f.ok  = (y > 10'(PUMP_REACH - 1));
            f.dir = UP;
         end
         KEY_S: begin
            f.ok  = (({1'b0, y} + 11'(PUMP_REACH)) < 11'(PLAY_H));
            f.dir = DOWN;
         end
         KEY_D: begin
            f.ok  = (({1'b0, x} + 11'(PUMP_REACH)) < 11'(PLAY_W));
            f.dir = RIGHT;
         end
         KEY_A: begin
            f.ok  = (x > 10'(PUMP_REACH - 1));
            f.dir = LEFT;
         end
         default: ;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector: one history register and an AND.
module rise_detect (
   input  logic Clk,
   input  logic Reset,
   input  logic d,
   output logic rise
);

   logic d_q;

   // Remember last cycle's value of d.
   always_ff @(posedge Clk) begin
      // NOTE: registers are written with <= so every flop samples pre-edge values.
      if (Reset) d_q <= 1'b0;
      else       d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/pump_ctrl.sv
// Pump weapon sequencer: extend, attach/inflate, retract, one step per frame tick.
module pump_ctrl
   import pump_pkg::*;
#(
   parameter int MAX_LEN        = 16,
   parameter int EXT_STEP       = 2,
   parameter int INFLATE_MAX    = 4,
   parameter int DEFLATE_FRAMES = 60
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic [7:0] last_key_press,
   input  logic [9:0] Ball_X_Loc,
   input  logic [9:0] Ball_Y_Loc,
   input  logic       enemy_hit,
   output logic       pump_active,
   output logic [1:0] pump_dir,
   output logic [4:0] pump_len,
   output logic [2:0] inflate_level,
   output logic       enemy_pop,
   output logic       player_freeze
);

   localparam int DC_W = $clog2(DEFLATE_FRAMES + 1);

   logic            frame_r;
   logic            tick;
   logic            space_now;
   logic            space_rise;
   logic            press_pend;
   logic            press_now;
   pump_state_t     state;
   logic [DC_W-1:0] defl_cnt;
   logic [DC_W-1:0] defl_inc;
   fire_t           fire;
   logic [5:0]      len_sum;
   logic [4:0]      len_inc;
   logic [4:0]      len_dec;
   logic [2:0]      lvl_inc;
   logic [2:0]      lvl_dec;

   // Bring frame_clk into the Clk domain before edge detection.
   always_ff @(posedge Clk) begin
      if (Reset) frame_r <= 1'b0;
      else       frame_r <= frame_clk;
   end

   rise_detect u_frame_rise (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (frame_r),
      .rise  (tick)
   );

   assign space_now = (keycode == KEY_SPACE);

   rise_detect u_space_rise (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (space_now),
      .rise  (space_rise)
   );

   // Hold a space press until the next tick consumes it.
   always_ff @(posedge Clk) begin
      if (Reset)           press_pend <= 1'b0;
      else if (tick)       press_pend <= 1'b0;
      else if (space_rise) press_pend <= 1'b1;
   end

   // A press landing on the tick cycle itself still counts for that tick.
   assign press_now = press_pend | space_rise;

   assign fire     = fire_check(last_key_press, Ball_X_Loc, Ball_Y_Loc);
   assign len_sum  = {1'b0, pump_len} + 6'(EXT_STEP);
   assign len_inc  = (len_sum > 6'(MAX_LEN)) ? 5'(MAX_LEN) : len_sum[4:0];
   assign len_dec  = (pump_len > 5'(EXT_STEP)) ? pump_len - 5'(EXT_STEP) : 5'd0;
   assign lvl_inc  = inflate_level + 3'd1;
   assign lvl_dec  = inflate_level - 3'd1;
   assign defl_inc = defl_cnt + DC_W'(1);

   // Pump state machine; all outputs are registered here.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= IDLE;
         pump_active   <= 1'b0;
         player_freeze <= 1'b0;
         pump_dir      <= 2'd0;
         pump_len      <= 5'd0;
         inflate_level <= 3'd0;
         enemy_pop     <= 1'b0;
         defl_cnt      <= '0;
      end else begin
         enemy_pop <= 1'b0;
         if (tick) begin
            unique case (state)
               IDLE: begin
                  if (space_now && fire.ok) begin
                     state         <= EXTEND;
                     pump_dir      <= fire.dir;
                     pump_len      <= 5'd0;
                     pump_active   <= 1'b1;
                     player_freeze <= 1'b1;
                  end
               end
               EXTEND: begin
                  if (!space_now) begin
                     state <= RETRACT;
                  end else if (enemy_hit) begin
                     state         <= ATTACHED;
                     inflate_level <= 3'd1;
                     defl_cnt      <= '0;
                  end else if (pump_len == 5'(MAX_LEN)) begin
                     state <= RETRACT;
                  end else begin
                     pump_len <= len_inc;
                  end
               end
               ATTACHED: begin
                  if (!enemy_hit) begin
                     state         <= RETRACT;
                     inflate_level <= 3'd0;
                  end else if (press_now) begin
                     defl_cnt <= '0;
                     if (lvl_inc == 3'(INFLATE_MAX)) begin
                        enemy_pop     <= 1'b1;
                        inflate_level <= 3'd0;
                        state         <= RETRACT;
                     end else begin
                        inflate_level <= lvl_inc;
                     end
                  end else if (defl_inc == DC_W'(DEFLATE_FRAMES)) begin
                     defl_cnt      <= '0;
                     inflate_level <= lvl_dec;
                     if (lvl_dec == 3'd0) state <= RETRACT;
                  end else begin
                     defl_cnt <= defl_inc;
                  end
               end
               RETRACT: begin
                  pump_len <= len_dec;
                  if (len_dec == 5'd0) begin
                     state         <= IDLE;
                     pump_active   <= 1'b0;
                     player_freeze <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pump_ctrl.sv
// Self-checking bench for pump_ctrl: per-cycle comparison against a tick-level model.
module tb_pump_ctrl;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [7:0] keycode;
   logic [7:0] last_key_press;
   logic [9:0] Ball_X_Loc;
   logic [9:0] Ball_Y_Loc;
   logic       enemy_hit;
   logic       pump_active;
   logic [1:0] pump_dir;
   logic [4:0] pump_len;
   logic [2:0] inflate_level;
   logic       enemy_pop;
   logic       player_freeze;

   always #5 Clk = ~Clk;

   pump_ctrl dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .frame_clk      (frame_clk),
      .keycode        (keycode),
      .last_key_press (last_key_press),
      .Ball_X_Loc     (Ball_X_Loc),
      .Ball_Y_Loc     (Ball_Y_Loc),
      .enemy_hit      (enemy_hit),
      .pump_active    (pump_active),
      .pump_dir       (pump_dir),
      .pump_len       (pump_len),
      .inflate_level  (inflate_level),
      .enemy_pop      (enemy_pop),
      .player_freeze  (player_freeze)
   );

   int checks   = 0;
   int failures = 0;
   int pop_seen = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phases: 0 idle, 1 extending, 2 attached, 3 retracting.
   int m_phase, m_len, m_lvl, m_dc, m_dir;
   bit m_pop, m_fr, m_frq, m_spq, m_pend;

   function automatic int dir_of(input int key, input int x, input int y);
      case (key)
         26:      return (y > 23)        ? 0 : -1;
         22:      return (y + 24 < 480)  ? 1 : -1;
         7:       return (x + 24 < 512)  ? 2 : -1;
         4:       return (x > 23)        ? 3 : -1;
         default: return -1;
      endcase
   endfunction

   always @(posedge Clk) begin : model
      bit tick, sp, press;
      int d;
      if (Reset) begin
         m_phase = 0; m_len = 0; m_lvl = 0; m_dc = 0; m_dir = 0;
         m_pop = 0; m_fr = 0; m_frq = 0; m_spq = 0; m_pend = 0;
      end else begin
         tick  = m_fr && !m_frq;
         sp    = (keycode == 8'd44);
         press = m_pend || (sp && !m_spq);
         m_pop = 0;
         if (tick) begin
            case (m_phase)
               0: begin
                  d = dir_of(last_key_press, Ball_X_Loc, Ball_Y_Loc);
                  if (sp && d >= 0) begin m_phase = 1; m_dir = d; m_len = 0; end
               end
               1: begin
                  if (!sp)                 m_phase = 3;
                  else if (enemy_hit)      begin m_phase = 2; m_lvl = 1; m_dc = 0; end
                  else if (m_len == 16)    m_phase = 3;
                  else                     m_len = (m_len + 2 > 16) ? 16 : m_len + 2;
               end
               2: begin
                  if (!enemy_hit) begin
                     m_phase = 3; m_lvl = 0;
                  end else if (press) begin
                     m_lvl++; m_dc = 0;
                     if (m_lvl == 4) begin m_pop = 1; m_lvl = 0; m_phase = 3; end
                  end else begin
                     m_dc++;
                     if (m_dc == 60) begin
                        m_dc = 0; m_lvl--;
                        if (m_lvl == 0) m_phase = 3;
                     end
                  end
               end
               default: begin
                  m_len = (m_len > 2) ? m_len - 2 : 0;
                  if (m_len == 0) m_phase = 0;
               end
            endcase
         end
         m_pend = !tick && press;
         m_frq  = m_fr;
         m_fr   = frame_clk;
         m_spq  = sp;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge Clk) begin
      if (cmp_en) begin
         check("pump_active",   pump_active,   (m_phase != 0));
         check("player_freeze", player_freeze, (m_phase != 0));
         check("pump_dir",      pump_dir,      m_dir);
         check("pump_len",      pump_len,      m_len);
         check("inflate_level", inflate_level, m_lvl);
         check("enemy_pop",     enemy_pop,     m_pop);
         if (enemy_pop === 1'b1) pop_seen++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic frame(input int hi = 4, input int lo = 4);
      frame_clk = 1'b1;
      cyc(hi);
      frame_clk = 1'b0;
      cyc(lo);
   endtask

   task automatic press_space();
      keycode = 8'd0;
      cyc(2);
      keycode = 8'd44;
      cyc(1);
      frame();
   endtask

   task automatic drain();
      keycode   = 8'd0;
      enemy_hit = 1'b0;
      for (int i = 0; i < 20 && m_phase != 0; i++) frame();
      check("drain_idle", pump_active, 1'b0);
   endtask

   int xs[8] = '{0, 20, 23, 24, 100, 487, 488, 700};
   int ys[8] = '{0, 20, 23, 24, 100, 455, 456, 600};
   int ks[5] = '{26, 22, 7, 4, 9};

   task automatic rand_frame();
      int hi = $urandom_range(2, 6);
      int lo = $urandom_range(2, 6);
      enemy_hit      = ($urandom_range(0, 9) < 7);
      last_key_press = 8'(ks[$urandom_range(0, 4)]);
      Ball_X_Loc     = 10'(xs[$urandom_range(0, 7)]);
      Ball_Y_Loc     = 10'(ys[$urandom_range(0, 7)]);
      frame_clk      = 1'b1;
      for (int c = 0; c < hi + lo; c++) begin
         if (c == hi) frame_clk = 1'b0;
         if ($urandom_range(0, 3) == 0)
            keycode = ($urandom_range(0, 2) != 0) ? 8'd44 : 8'($urandom_range(0, 60));
         @(negedge Clk);
      end
   endtask

   // ---------------- directed and random sequences ----------------
   initial begin
      int pop_base;
      Reset = 1'b1; frame_clk = 1'b0; keycode = 8'd0; last_key_press = 8'd0;
      Ball_X_Loc = 10'd0; Ball_Y_Loc = 10'd0; enemy_hit = 1'b0;
      cyc(2);
      cmp_en = 1'b1;
      cyc(1);
      check("reset_active", pump_active, 1'b0);
      check("reset_len", pump_len, 5'd0);
      Reset = 1'b0;
      cyc(2);

      // Full extend to MAX_LEN and retract with no enemy.
      last_key_press = 8'd7; Ball_X_Loc = 10'd100; Ball_Y_Loc = 10'd100; keycode = 8'd44;
      frame();
      check("t1_fire_active", pump_active, 1'b1);
      check("t1_fire_len", pump_len, 5'd0);
      check("t1_dir_right", pump_dir, 2'd2);
      for (int i = 1; i <= 8; i++) begin
         frame();
         check("t1_ext_len", pump_len, 32'(2 * i));
         check("t1_ext_freeze", player_freeze, 1'b1);
      end
      frame();
      check("t1_at_max_len", pump_len, 5'd16);
      for (int i = 1; i <= 8; i++) begin
         frame();
         check("t1_ret_len", pump_len, 32'(16 - 2 * i));
         check("t1_ret_freeze", player_freeze, (i < 8));
      end
      keycode = 8'd0;
      drain();

      // Facing left too close to the left wall: no shot.
      last_key_press = 8'd4; Ball_X_Loc = 10'd20; keycode = 8'd44;
      repeat (3) frame();
      check("t2_blocked", pump_active, 1'b0);
      drain();

      // Attach on the third extend step and pop with three presses.
      last_key_press = 8'd26; Ball_X_Loc = 10'd100; Ball_Y_Loc = 10'd100; keycode = 8'd44;
      frame(); frame(); frame();
      enemy_hit = 1'b1;
      frame();
      check("t3_attach_len", pump_len, 5'd4);
      check("t3_attach_lvl", inflate_level, 3'd1);
      check("t3_dir_up", pump_dir, 2'd0);
      press_space();
      check("t3_lvl2", inflate_level, 3'd2);
      press_space();
      check("t3_lvl3", inflate_level, 3'd3);
      pop_base = pop_seen;
      press_space();
      check("t3_pop_count", pop_seen - pop_base, 1);
      check("t3_pop_lvl", inflate_level, 3'd0);
      check("t3_retract_len", pump_len, 5'd4);
      check("t3_retract_active", pump_active, 1'b1);
      drain();

      // Slow deflation from level 2 with no presses.
      keycode = 8'd44; enemy_hit = 1'b0;
      frame(); frame();
      enemy_hit = 1'b1;
      frame();
      press_space();
      keycode = 8'd0;
      check("t4_start_lvl", inflate_level, 3'd2);
      pop_base = pop_seen;
      repeat (59) frame();
      check("t4_lvl_59", inflate_level, 3'd2);
      frame();
      check("t4_lvl_60", inflate_level, 3'd1);
      repeat (59) frame();
      check("t4_lvl_119", inflate_level, 3'd1);
      frame();
      check("t4_lvl_120", inflate_level, 3'd0);
      check("t4_retracting", pump_active, 1'b1);
      check("t4_no_pop", pop_seen - pop_base, 0);
      drain();

      // Holding space counts as a single press.
      last_key_press = 8'd7; keycode = 8'd44;
      frame(); frame();
      enemy_hit = 1'b1;
      frame();
      keycode = 8'd0; cyc(2); keycode = 8'd44;
      repeat (10) frame();
      check("t5_single_inc", inflate_level, 3'd2);
      drain();

      // Reset in the middle of extension, then a fresh shot.
      keycode = 8'd44;
      repeat (4) frame();
      check("t6_len6", pump_len, 5'd6);
      Reset = 1'b1;
      cyc(1);
      Reset = 1'b0;
      check("t6_rst_active", pump_active, 1'b0);
      check("t6_rst_len", pump_len, 5'd0);
      check("t6_rst_freeze", player_freeze, 1'b0);
      check("t6_rst_dir", pump_dir, 2'd0);
      frame();
      check("t6_refire_active", pump_active, 1'b1);
      check("t6_refire_len", pump_len, 5'd0);
      frame();
      check("t6_refire_step", pump_len, 5'd2);
      drain();

      // Randomized traffic checked cycle by cycle against the model.
      for (int f = 0; f < 400; f++) rand_frame();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog simulation did not complete actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
